axil_arbiter_2to1: RTL and testbench

//  Shares one AXI4-Lite slave (the 16x32b register file) between two AXI4-Lite masters:

---
 rtl/axil_arbiter_2to1_pkg.sv | 37 +++
 rtl/axil_arbiter_2to1_rr_arb2.sv | 50 +++++
 rtl/axil_arbiter_2to1.sv | 278 +++++++++++++++++++++++++++
 tb/tb_axil_arbiter_2to1.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_arbiter_2to1_pkg.sv
// Shared types for the 2:1 AXI4-Lite arbiter: bus widths, flattened
// request/response bundles and the per-channel FSM state encodings.
package axil_pkg;

  localparam int ADDR_W = 40;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              rready;
  } axil_req_t;

  typedef struct packed {
    logic              awready;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
  } axil_rsp_t;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} wr_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_RESP = 2'd2} rd_state_e;

endpackage

// File: rtl/axil_arbiter_2to1_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from the request
// vector; the priority pointer moves to the port opposite the finishing
// owner when the channel signals completion.
module axil_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       owner_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // Next pointer: after a completed transaction the other port gets priority
  always_comb begin
    if (advance_i) begin
      ptr_d = ~owner_i;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, starts favouring port 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // One-hot grant: lone requester wins, ties resolved by the pointer
  always_comb begin
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11: begin
        if (ptr_q) begin
          gnt_o = 2'b10;
        end else begin
          gnt_o = 2'b01;
        end
      end
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/axil_arbiter_2to1.sv
// Shares one AXI4-Lite slave between two masters. Write and read channels
// each run a small FSM with one outstanding transaction and their own
// round-robin arbiter. Request payloads toward the slave are registered;
// responses are steered combinationally to the current owner.
module axil_arbiter_2to1
  import axil_pkg::*;
(
  input  logic       axi_aclk,
  input  logic       axi_aresetn,
  input  axil_req_t  s_req [2],
  output axil_rsp_t  s_rsp [2],
  output axil_req_t  m_req,
  input  axil_rsp_t  m_rsp,
  output logic [1:0] wr_grant,
  output logic [1:0] rd_grant
);

  wr_state_e         w_state_q, w_state_d;
  logic [1:0]        w_gnt_q, w_gnt_d;
  logic              aw_valid_q, aw_valid_d;
  logic              w_valid_q, w_valid_d;
  logic              w_cap_q, w_cap_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [2:0]        awprot_q, awprot_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [1:0]        w_arb_gnt_s;
  logic              w_adv_s;
  logic              w_own_s;
  logic              w_win_s;

  rd_state_e         r_state_q, r_state_d;
  logic [1:0]        r_gnt_q, r_gnt_d;
  logic              ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [2:0]        arprot_q, arprot_d;
  logic [1:0]        r_arb_gnt_s;
  logic              r_adv_s;
  logic              r_own_s;
  logic              r_win_s;

  assign w_own_s  = w_gnt_q[1];
  assign w_win_s  = w_arb_gnt_s[1];
  assign r_own_s  = r_gnt_q[1];
  assign r_win_s  = r_arb_gnt_s[1];
  assign wr_grant = w_gnt_q;
  assign rd_grant = r_gnt_q;

  axil_rr_arb2 u_wr_arb (
    .clk_i     (axi_aclk),
    .rst_ni    (axi_aresetn),
    .req_i     ({s_req[1].awvalid, s_req[0].awvalid}),
    .advance_i (w_adv_s),
    .owner_i   (w_own_s),
    .gnt_o     (w_arb_gnt_s)
  );

  axil_rr_arb2 u_rd_arb (
    .clk_i     (axi_aclk),
    .rst_ni    (axi_aresetn),
    .req_i     ({s_req[1].arvalid, s_req[0].arvalid}),
    .advance_i (r_adv_s),
    .owner_i   (r_own_s),
    .gnt_o     (r_arb_gnt_s)
  );

  // Write FSM next state: grant + latch, forward AW/W independently, await B
  always_comb begin
    w_state_d  = w_state_q;
    w_gnt_d    = w_gnt_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    w_cap_d    = w_cap_q;
    awaddr_d   = awaddr_q;
    awprot_d   = awprot_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    w_adv_s    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (w_arb_gnt_s != 2'b00) begin
          w_gnt_d    = w_arb_gnt_s;
          aw_valid_d = 1'b1;
          awaddr_d   = s_req[w_win_s].awaddr;
          awprot_d   = s_req[w_win_s].awprot;
          // W may arrive with, before or after AW; capture it now if present
          if (s_req[w_win_s].wvalid) begin
            w_cap_d   = 1'b1;
            w_valid_d = 1'b1;
            wdata_d   = s_req[w_win_s].wdata;
            wstrb_d   = s_req[w_win_s].wstrb;
          end else begin
            w_cap_d   = 1'b0;
            w_valid_d = 1'b0;
          end
          w_state_d = W_XFER;
        end else begin
          w_gnt_d = 2'b00;
        end
      end
      W_XFER: begin
        if (aw_valid_q && m_rsp.awready) begin
          aw_valid_d = 1'b0;
        end else begin
          aw_valid_d = aw_valid_q;
        end
        if (w_valid_q && m_rsp.wready) begin
          w_valid_d = 1'b0;
        end else if (!w_cap_q && s_req[w_own_s].wvalid) begin
          w_cap_d   = 1'b1;
          w_valid_d = 1'b1;
          wdata_d   = s_req[w_own_s].wdata;
          wstrb_d   = s_req[w_own_s].wstrb;
        end else begin
          w_valid_d = w_valid_q;
        end
        if (!aw_valid_d && w_cap_d && !w_valid_d) begin
          w_state_d = W_RESP;
        end else begin
          w_state_d = W_XFER;
        end
      end
      W_RESP: begin
        if (m_rsp.bvalid && s_req[w_own_s].bready) begin
          w_adv_s   = 1'b1;
          w_gnt_d   = 2'b00;
          w_cap_d   = 1'b0;
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d  = W_IDLE;
        w_gnt_d    = 2'b00;
        aw_valid_d = 1'b0;
        w_valid_d  = 1'b0;
        w_cap_d    = 1'b0;
      end
    endcase
  end

  // Read FSM next state: grant + latch AR, forward AR, await R
  always_comb begin
    r_state_d  = r_state_q;
    r_gnt_d    = r_gnt_q;
    ar_valid_d = ar_valid_q;
    araddr_d   = araddr_q;
    arprot_d   = arprot_q;
    r_adv_s    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (r_arb_gnt_s != 2'b00) begin
          r_gnt_d    = r_arb_gnt_s;
          ar_valid_d = 1'b1;
          araddr_d   = s_req[r_win_s].araddr;
          arprot_d   = s_req[r_win_s].arprot;
          r_state_d  = R_ADDR;
        end else begin
          r_gnt_d = 2'b00;
        end
      end
      R_ADDR: begin
        if (m_rsp.arready) begin
          ar_valid_d = 1'b0;
          r_state_d  = R_RESP;
        end else begin
          r_state_d  = R_ADDR;
        end
      end
      R_RESP: begin
        if (m_rsp.rvalid && s_req[r_own_s].rready) begin
          r_adv_s   = 1'b1;
          r_gnt_d   = 2'b00;
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_RESP;
        end
      end
      default: begin
        r_state_d  = R_IDLE;
        r_gnt_d    = 2'b00;
        ar_valid_d = 1'b0;
      end
    endcase
  end

  // State, grant and payload registers for both channels
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      w_state_q  <= W_IDLE;
      w_gnt_q    <= 2'b00;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      w_cap_q    <= 1'b0;
      awaddr_q   <= {ADDR_W{1'b0}};
      awprot_q   <= 3'b000;
      wdata_q    <= {DATA_W{1'b0}};
      wstrb_q    <= {STRB_W{1'b0}};
      r_state_q  <= R_IDLE;
      r_gnt_q    <= 2'b00;
      ar_valid_q <= 1'b0;
      araddr_q   <= {ADDR_W{1'b0}};
      arprot_q   <= 3'b000;
    end else begin
      w_state_q  <= w_state_d;
      w_gnt_q    <= w_gnt_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      w_cap_q    <= w_cap_d;
      awaddr_q   <= awaddr_d;
      awprot_q   <= awprot_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      r_state_q  <= r_state_d;
      r_gnt_q    <= r_gnt_d;
      ar_valid_q <= ar_valid_d;
      araddr_q   <= araddr_d;
      arprot_q   <= arprot_d;
    end
  end

  // Slave-side request: registered payload, B/R ready from the owner only
  always_comb begin
    m_req         = '0;
    m_req.awaddr  = awaddr_q;
    m_req.awprot  = awprot_q;
    m_req.awvalid = aw_valid_q;
    m_req.wdata   = wdata_q;
    m_req.wstrb   = wstrb_q;
    m_req.wvalid  = w_valid_q;
    m_req.araddr  = araddr_q;
    m_req.arprot  = arprot_q;
    m_req.arvalid = ar_valid_q;
    if (w_state_q == W_RESP) begin
      m_req.bready = s_req[w_own_s].bready;
    end else begin
      m_req.bready = 1'b0;
    end
    if (r_state_q == R_RESP) begin
      m_req.rready = s_req[r_own_s].rready;
    end else begin
      m_req.rready = 1'b0;
    end
  end

  // Master-side responses: steer slave handshakes to the granted port only
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      s_rsp[i] = '0;
      if (w_gnt_q[i]) begin
        s_rsp[i].awready = m_rsp.awready & aw_valid_q;
        s_rsp[i].wready  = m_rsp.wready & w_valid_q;
        if (w_state_q == W_RESP) begin
          s_rsp[i].bvalid = m_rsp.bvalid;
          s_rsp[i].bresp  = m_rsp.bresp;
        end else begin
          s_rsp[i].bvalid = 1'b0;
        end
      end else begin
        s_rsp[i].awready = 1'b0;
      end
      if (r_gnt_q[i]) begin
        s_rsp[i].arready = m_rsp.arready & ar_valid_q;
        if (r_state_q == R_RESP) begin
          s_rsp[i].rvalid = m_rsp.rvalid;
          s_rsp[i].rdata  = m_rsp.rdata;
          s_rsp[i].rresp  = m_rsp.rresp;
        end else begin
          s_rsp[i].rvalid = 1'b0;
        end
      end else begin
        s_rsp[i].arready = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Directed bench for the 2:1 AXI4-Lite arbiter. Inputs change and outputs
// are sampled on the falling clock edge; the slave side is driven by hand.
module tb_axil_arbiter_2to1;
  import axil_pkg::*;

  logic       axi_aclk;
  logic       axi_aresetn;
  axil_req_t  s_req [2];
  axil_rsp_t  s_rsp [2];
  axil_req_t  m_req;
  axil_rsp_t  m_rsp;
  logic [1:0] wr_grant;
  logic [1:0] rd_grant;

  int n_cmp;
  int n_bad;

  axil_arbiter_2to1 dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .s_req       (s_req),
    .s_rsp       (s_rsp),
    .m_req       (m_req),
    .m_rsp       (m_rsp),
    .wr_grant    (wr_grant),
    .rd_grant    (rd_grant)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    s_req[0] = '0;
    s_req[1] = '0;
    m_rsp    = '0;
  endtask

  task automatic do_reset();
    @(negedge axi_aclk);
    axi_aresetn = 1'b0;
    clear_inputs();
    @(negedge axi_aclk);
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
  endtask

  // Zero-wait slave completion of a write already presented on m_req
  task automatic zw_write(input int port);
    m_rsp.awready = 1'b1;
    m_rsp.wready  = 1'b1;
    @(negedge axi_aclk);
    m_rsp.awready = 1'b0;
    m_rsp.wready  = 1'b0;
    s_req[port].awvalid = 1'b0;
    s_req[port].wvalid  = 1'b0;
    m_rsp.bvalid = 1'b1;
    m_rsp.bresp  = 2'b00;
    @(negedge axi_aclk);
    m_rsp.bvalid = 1'b0;
  endtask

  task automatic test_reset();
    m_rsp.awready = 1'b1;
    m_rsp.wready  = 1'b1;
    m_rsp.arready = 1'b1;
    m_rsp.bvalid  = 1'b1;
    m_rsp.rvalid  = 1'b1;
    #1;
    n_cmp++; if ({m_req.awvalid, m_req.wvalid, m_req.arvalid, m_req.bready, m_req.rready} !== 5'b00000) begin n_bad++; $display("FAIL reset_m_req: got %b want 00000", {m_req.awvalid, m_req.wvalid, m_req.arvalid, m_req.bready, m_req.rready}); end
    n_cmp++; if ({wr_grant, rd_grant} !== 4'b0000) begin n_bad++; $display("FAIL reset_grants: got %b want 0000", {wr_grant, rd_grant}); end
    n_cmp++; if ({s_rsp[0].awready, s_rsp[0].wready, s_rsp[0].arready, s_rsp[0].bvalid, s_rsp[0].rvalid,
                  s_rsp[1].awready, s_rsp[1].wready, s_rsp[1].arready, s_rsp[1].bvalid, s_rsp[1].rvalid} !== 10'b0)
      begin n_bad++; $display("FAIL reset_s_rsp: a port response bit is high after reset"); end
    clear_inputs();
  endtask

  task automatic test_single_write();
    @(negedge axi_aclk);
    s_req[0].awaddr = 40'h08; s_req[0].awvalid = 1'b1;
    s_req[0].wdata = 32'h12345678; s_req[0].wstrb = 4'hF; s_req[0].wvalid = 1'b1;
    s_req[0].bready = 1'b1;
    @(negedge axi_aclk);
    n_cmp++; if (wr_grant !== 2'b01) begin n_bad++; $display("FAIL t1_grant: got %b want 01", wr_grant); end
    n_cmp++; if (m_req.awaddr !== 40'h08 || m_req.awvalid !== 1'b1) begin n_bad++; $display("FAIL t1_awaddr: got %h/%b want 08/1", m_req.awaddr, m_req.awvalid); end
    n_cmp++; if (m_req.wdata !== 32'h12345678 || m_req.wvalid !== 1'b1) begin n_bad++; $display("FAIL t1_wdata: got %h/%b want 12345678/1", m_req.wdata, m_req.wvalid); end
    m_rsp.awready = 1'b1; m_rsp.wready = 1'b1;
    #1;
    n_cmp++; if ({s_rsp[0].awready, s_rsp[0].wready, s_rsp[1].awready, s_rsp[1].wready} !== 4'b1100) begin n_bad++; $display("FAIL t1_readys: got %b want 1100", {s_rsp[0].awready, s_rsp[0].wready, s_rsp[1].awready, s_rsp[1].wready}); end
    @(negedge axi_aclk);
    m_rsp.awready = 1'b0; m_rsp.wready = 1'b0;
    s_req[0].awvalid = 1'b0; s_req[0].wvalid = 1'b0;
    m_rsp.bvalid = 1'b1; m_rsp.bresp = 2'b00;
    #1;
    n_cmp++; if ({s_rsp[0].bvalid, s_rsp[1].bvalid, m_req.bready} !== 3'b101) begin n_bad++; $display("FAIL t1_bvalid: got %b want 101", {s_rsp[0].bvalid, s_rsp[1].bvalid, m_req.bready}); end
    n_cmp++; if ({m_req.awvalid, m_req.wvalid} !== 2'b00) begin n_bad++; $display("FAIL t1_valid_drop: got %b want 00", {m_req.awvalid, m_req.wvalid}); end
    @(negedge axi_aclk);
    m_rsp.bvalid = 1'b0;
    n_cmp++; if (wr_grant !== 2'b00) begin n_bad++; $display("FAIL t1_grant_clear: got %b want 00", wr_grant); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    s_req[0].awaddr = 40'h10; s_req[0].awvalid = 1'b1; s_req[0].wdata = 32'h0000_0010; s_req[0].wstrb = 4'hF; s_req[0].wvalid = 1'b1; s_req[0].bready = 1'b1;
    s_req[1].awaddr = 40'h14; s_req[1].awvalid = 1'b1; s_req[1].wdata = 32'h0000_0014; s_req[1].wstrb = 4'hF; s_req[1].wvalid = 1'b1; s_req[1].bready = 1'b1;
    @(negedge axi_aclk);
    n_cmp++; if (wr_grant !== 2'b01 || m_req.awaddr !== 40'h10) begin n_bad++; $display("FAIL t2_first: got %b/%h want 01/10", wr_grant, m_req.awaddr); end
    zw_write(0);
    n_cmp++; if (wr_grant !== 2'b00) begin n_bad++; $display("FAIL t2_gap: got %b want 00", wr_grant); end
    // port 0 comes straight back while port 1 still waits: pointer now favours port 1
    s_req[0].awaddr = 40'h18; s_req[0].awvalid = 1'b1; s_req[0].wdata = 32'h0000_0018; s_req[0].wvalid = 1'b1;
    @(negedge axi_aclk);
    n_cmp++; if (wr_grant !== 2'b10 || m_req.awaddr !== 40'h14 || m_req.wdata !== 32'h0000_0014) begin n_bad++; $display("FAIL t2_second: got %b/%h/%h want 10/14/00000014", wr_grant, m_req.awaddr, m_req.wdata); end
    zw_write(1);
    @(negedge axi_aclk);
    n_cmp++; if (wr_grant !== 2'b01 || m_req.awaddr !== 40'h18) begin n_bad++; $display("FAIL t2_third: got %b/%h want 01/18", wr_grant, m_req.awaddr); end
    zw_write(0);
    clear_inputs();
  endtask

  task automatic test_w_before_aw();
    int wv_cnt;
    int p0_bad;
    wv_cnt = 0;
    p0_bad = 0;
    s_req[1].wdata = 32'hA5A5_0003; s_req[1].wstrb = 4'h3; s_req[1].wvalid = 1'b1; s_req[1].bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge axi_aclk);
      #1;
      n_cmp++; if (wr_grant !== 2'b00 || s_rsp[1].wready !== 1'b0) begin n_bad++; $display("FAIL t3_w_only: got %b/%b want 00/0", wr_grant, s_rsp[1].wready); end
    end
    s_req[1].awaddr = 40'h20; s_req[1].awvalid = 1'b1;
    @(negedge axi_aclk);
    n_cmp++; if (wr_grant !== 2'b10 || m_req.wdata !== 32'hA5A5_0003 || m_req.wstrb !== 4'h3) begin n_bad++; $display("FAIL t3_grant: got %b/%h/%h want 10/a5a50003/3", wr_grant, m_req.wdata, m_req.wstrb); end
    wv_cnt += int'(m_req.wvalid);
    m_rsp.wready = 1'b1;
    #1;
    n_cmp++; if ({s_rsp[1].awready, s_rsp[1].wready} !== 2'b01) begin n_bad++; $display("FAIL t3_w_first: got %b want 01", {s_rsp[1].awready, s_rsp[1].wready}); end
    p0_bad += int'(s_rsp[0].awready | s_rsp[0].wready);
    @(negedge axi_aclk);
    s_req[1].wvalid = 1'b0; m_rsp.wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      wv_cnt += int'(m_req.wvalid);
      p0_bad += int'(s_rsp[0].awready | s_rsp[0].wready);
      n_cmp++; if (m_req.awvalid !== 1'b1 || m_req.awaddr !== 40'h20) begin n_bad++; $display("FAIL t3_aw_stall: got %b/%h want 1/20", m_req.awvalid, m_req.awaddr); end
      @(negedge axi_aclk);
    end
    m_rsp.awready = 1'b1;
    #1;
    wv_cnt += int'(m_req.wvalid);
    p0_bad += int'(s_rsp[0].awready | s_rsp[0].wready);
    n_cmp++; if (s_rsp[1].awready !== 1'b1) begin n_bad++; $display("FAIL t3_aw_done: got %b want 1", s_rsp[1].awready); end
    @(negedge axi_aclk);
    s_req[1].awvalid = 1'b0; m_rsp.awready = 1'b0; m_rsp.bvalid = 1'b1;
    #1;
    wv_cnt += int'(m_req.wvalid);
    p0_bad += int'(s_rsp[0].awready | s_rsp[0].wready);
    n_cmp++; if (s_rsp[1].bvalid !== 1'b1 || m_req.wdata !== 32'hA5A5_0003) begin n_bad++; $display("FAIL t3_b: got %b/%h want 1/a5a50003", s_rsp[1].bvalid, m_req.wdata); end
    @(negedge axi_aclk);
    m_rsp.bvalid = 1'b0;
    n_cmp++; if (wv_cnt !== 1) begin n_bad++; $display("FAIL t3_single_w: got %0d want 1", wv_cnt); end
    n_cmp++; if (p0_bad !== 0) begin n_bad++; $display("FAIL t3_p0_quiet: got %0d want 0", p0_bad); end
    clear_inputs();
  endtask

  task automatic test_concurrent();
    s_req[0].awaddr = 40'h0C; s_req[0].awvalid = 1'b1; s_req[0].wdata = 32'h0BAD_F00D; s_req[0].wstrb = 4'hF; s_req[0].wvalid = 1'b1; s_req[0].bready = 1'b1;
    s_req[1].araddr = 40'h00; s_req[1].arvalid = 1'b1; s_req[1].rready = 1'b1;
    @(negedge axi_aclk);
    n_cmp++; if ({wr_grant, rd_grant} !== 4'b0110 || m_req.arvalid !== 1'b1 || m_req.awaddr !== 40'h0C) begin n_bad++; $display("FAIL t4_grants: got %b/%b/%h want 0110/1/0c", {wr_grant, rd_grant}, m_req.arvalid, m_req.awaddr); end
    m_rsp.awready = 1'b1; m_rsp.wready = 1'b1; m_rsp.arready = 1'b1;
    #1;
    n_cmp++; if ({s_rsp[0].awready, s_rsp[0].arready, s_rsp[1].awready, s_rsp[1].arready} !== 4'b1001) begin n_bad++; $display("FAIL t4_readys: got %b want 1001", {s_rsp[0].awready, s_rsp[0].arready, s_rsp[1].awready, s_rsp[1].arready}); end
    @(negedge axi_aclk);
    clear_inputs();
    s_req[0].bready = 1'b1; s_req[1].rready = 1'b1;
    m_rsp.bvalid = 1'b1; m_rsp.rvalid = 1'b1; m_rsp.rdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (s_rsp[1].rvalid !== 1'b1 || s_rsp[1].rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL t4_rdata: got %b/%h want 1/deadbeef", s_rsp[1].rvalid, s_rsp[1].rdata); end
    n_cmp++; if ({s_rsp[0].bvalid, s_rsp[0].rvalid, s_rsp[1].bvalid, m_req.bready, m_req.rready} !== 5'b10011) begin n_bad++; $display("FAIL t4_crosstalk: got %b want 10011", {s_rsp[0].bvalid, s_rsp[0].rvalid, s_rsp[1].bvalid, m_req.bready, m_req.rready}); end
    @(negedge axi_aclk);
    m_rsp = '0;
    n_cmp++; if ({wr_grant, rd_grant} !== 4'b0000) begin n_bad++; $display("FAIL t4_done: got %b want 0000", {wr_grant, rd_grant}); end
    clear_inputs();
  endtask

  task automatic test_resp_hold();
    s_req[1].awaddr = 40'h24; s_req[1].awvalid = 1'b1; s_req[1].wdata = 32'h0000_0024; s_req[1].wstrb = 4'hF; s_req[1].wvalid = 1'b1;
    s_req[0].araddr = 40'h28; s_req[0].arvalid = 1'b1;
    @(negedge axi_aclk);
    m_rsp.awready = 1'b1; m_rsp.wready = 1'b1; m_rsp.arready = 1'b1;
    @(negedge axi_aclk);
    clear_inputs();
    m_rsp.bvalid = 1'b1; m_rsp.bresp = 2'b10;
    m_rsp.rvalid = 1'b1; m_rsp.rresp = 2'b10; m_rsp.rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (s_rsp[1].bvalid !== 1'b1 || s_rsp[1].bresp !== 2'b10 || m_req.bready !== 1'b0 || wr_grant !== 2'b10) begin n_bad++; $display("FAIL t5_b_hold: got %b/%b/%b/%b want 1/10/0/10", s_rsp[1].bvalid, s_rsp[1].bresp, m_req.bready, wr_grant); end
      n_cmp++; if (s_rsp[0].rvalid !== 1'b1 || s_rsp[0].rresp !== 2'b10 || s_rsp[0].rdata !== 32'hCAFEF00D || m_req.rready !== 1'b0) begin n_bad++; $display("FAIL t5_r_hold: got %b/%b/%h/%b want 1/10/cafef00d/0", s_rsp[0].rvalid, s_rsp[0].rresp, s_rsp[0].rdata, m_req.rready); end
      @(negedge axi_aclk);
    end
    s_req[1].bready = 1'b1; s_req[0].rready = 1'b1;
    #1;
    n_cmp++; if ({m_req.bready, m_req.rready} !== 2'b11) begin n_bad++; $display("FAIL t5_accept: got %b want 11", {m_req.bready, m_req.rready}); end
    @(negedge axi_aclk);
    m_rsp = '0;
    n_cmp++; if ({wr_grant, rd_grant} !== 4'b0000) begin n_bad++; $display("FAIL t5_done: got %b want 0000", {wr_grant, rd_grant}); end
    clear_inputs();
  endtask

  task automatic test_reset_midway();
    s_req[0].awaddr = 40'h30; s_req[0].awvalid = 1'b1; s_req[0].wdata = 32'h0000_0030; s_req[0].wstrb = 4'hF; s_req[0].wvalid = 1'b1;
    @(negedge axi_aclk);
    n_cmp++; if (m_req.awvalid !== 1'b1 || wr_grant !== 2'b01) begin n_bad++; $display("FAIL t6_xfer: got %b/%b want 1/01", m_req.awvalid, wr_grant); end
    #2;
    axi_aresetn = 1'b0;
    m_rsp.awready = 1'b1;
    #1;
    n_cmp++; if ({m_req.awvalid, m_req.wvalid, wr_grant, s_rsp[0].awready} !== 5'b00000) begin n_bad++; $display("FAIL t6_async: got %b want 00000", {m_req.awvalid, m_req.wvalid, wr_grant, s_rsp[0].awready}); end
    clear_inputs();
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    s_req[1].araddr = 40'h04; s_req[1].arvalid = 1'b1; s_req[1].rready = 1'b1;
    @(negedge axi_aclk);
    n_cmp++; if (rd_grant !== 2'b10 || m_req.araddr !== 40'h04 || wr_grant !== 2'b00) begin n_bad++; $display("FAIL t6_read_grant: got %b/%h/%b want 10/04/00", rd_grant, m_req.araddr, wr_grant); end
    m_rsp.arready = 1'b1;
    @(negedge axi_aclk);
    s_req[1].arvalid = 1'b0; m_rsp.arready = 1'b0;
    m_rsp.rvalid = 1'b1; m_rsp.rdata = 32'h600DF00D;
    #1;
    n_cmp++; if (s_rsp[1].rvalid !== 1'b1 || s_rsp[1].rdata !== 32'h600DF00D) begin n_bad++; $display("FAIL t6_rdata: got %b/%h want 1/600df00d", s_rsp[1].rvalid, s_rsp[1].rdata); end
    @(negedge axi_aclk);
    m_rsp = '0;
    n_cmp++; if (rd_grant !== 2'b00) begin n_bad++; $display("FAIL t6_done: got %b want 00", rd_grant); end
    clear_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    axi_aresetn = 1'b0;
    clear_inputs();
    @(negedge axi_aclk);
    test_reset();
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    test_single_write();
    test_round_robin();
    test_w_before_aw();
    test_concurrent();
    test_resp_hold();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
